// File: rtl/ece571f23_g5_aes_pkg.sv
// Shared AES-128 definitions: S-box, round constants, block type and FSM encoding
// for the iterative cipher core.
package ece571f23_g5_aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned BLK_W = 128;

  typedef logic [BLK_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Indexed by round number; entries outside 1..10 are never used.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    return RCON[r];
  endfunction

endpackage

// File: rtl/ece571f23_g5_aes_round.sv
// One combinational AES-128 encryption round plus the matching key-schedule step.
module ece571f23_g5_aes_round
  import ece571f23_g5_aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rkey_in,
  input  logic [7:0]   rcon_in,
  input  logic         last,
  output logic [127:0] state_out,
  output logic [127:0] rkey_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [31:0]  w0, w1, w2, w3, tmp;
  logic [31:0]  k0, k1, k2, k3;
  logic [127:0] sr, mc;

  // Next round key derived from the previous one
  assign w0  = rkey_in[127:96];
  assign w1  = rkey_in[95:64];
  assign w2  = rkey_in[63:32];
  assign w3  = rkey_in[31:0];
  assign tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon_in, 24'h000000};
  assign k0  = w0 ^ tmp;
  assign k1  = w1 ^ k0;
  assign k2  = w2 ^ k1;
  assign k3  = w3 ^ k2;
  assign rkey_out = {k0, k1, k2, k3};

  // Byte n of the block sits at row n%4, column n/4
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sbox(state_in[127-8*(4*((c+r)%4)+r) -: 8]);
    end

    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];

    assign mc[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end

  assign state_out = (last ? sr : mc) ^ rkey_out;

endmodule

// File: rtl/ece571f23_g5_aes_cipher_iter.sv
// Iterative AES-128 encryption core, UNROLL rounds per clock, optional CBC chaining,
// valid/ready handshakes on both sides.
module ece571f23_g5_aes_cipher_iter
  import ece571f23_g5_aes_pkg::*;
#(
  parameter int unsigned UNROLL = 1,
  parameter bit          CBC_EN = 1'b0
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  input  logic         iv_load,
  input  logic [127:0] iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5)) begin : g_bad_unroll
    $error("ece571f23_g5_aes_cipher_iter: UNROLL must be 1, 2 or 5");
  end

  fsm_state_t   fsm_q;
  aes_state_t   state_q, rkey_q, chain_q, cipher_q;
  logic [3:0]   round_q;
  logic         out_valid_q, busy_q;

  logic         hs, accept, iv_take, last_step;
  aes_state_t   chain_eff, init_state;
  logic [UNROLL:0][127:0] st_chain, rk_chain;

  assign st_chain[0] = state_q;
  assign rk_chain[0] = rkey_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    logic [3:0] rnd;
    assign rnd = round_q + 4'(i);

    ece571f23_g5_aes_round u_round (
      .state_in  (st_chain[i]),
      .rkey_in   (rk_chain[i]),
      .rcon_in   (rcon(rnd)),
      .last      (rnd == 4'(NR)),
      .state_out (st_chain[i+1]),
      .rkey_out  (rk_chain[i+1])
    );
  end

  assign last_step = (round_q + 4'(UNROLL - 1)) == 4'(NR);
  assign hs        = (fsm_q == DONE) && out_ready;
  assign in_ready  = (fsm_q == IDLE) || hs;
  assign accept    = in_valid && in_ready;
  assign iv_take   = CBC_EN && iv_load && (fsm_q == IDLE);

  // Chain value seen by a block accepted this edge: fresh iv, or the cipher being handed off
  always_comb begin
    chain_eff = chain_q;
    if (iv_take)  chain_eff = iv;
    else if (hs)  chain_eff = cipher_q;
  end

  assign init_state = plaintext ^ key ^ (CBC_EN ? chain_eff : aes_state_t'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rkey_q      <= '0;
      round_q     <= '0;
      chain_q     <= '0;
      cipher_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (iv_take || (CBC_EN && hs)) chain_q <= chain_eff;

      case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_q <= init_state;
            rkey_q  <= key;
            round_q <= 4'd1;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= st_chain[UNROLL];
          rkey_q  <= rk_chain[UNROLL];
          round_q <= round_q + 4'(UNROLL);
          if (last_step) begin
            cipher_q    <= st_chain[UNROLL];
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            fsm_q       <= DONE;
          end
        end
        DONE: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              state_q <= init_state;
              rkey_q  <= key;
              round_q <= 4'd1;
              busy_q  <= 1'b1;
              fsm_q   <= RUN;
            end else begin
              fsm_q <= IDLE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign cipher    = cipher_q;

endmodule

// File: tb/tb_ece571f23_g5_aes_cipher_iter.sv
// Bench for the iterative AES core: three instances (UNROLL 1/2/5, last one CBC)
// checked against a byte-level AES-128 model built from GF(2^8) arithmetic.
module tb_ece571f23_g5_aes_cipher_iter;

  localparam int NI = 3;
  localparam int LAT [NI] = '{10, 5, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [NI];
  logic         out_ready [NI];
  logic         iv_load   [NI];
  logic [127:0] plaintext [NI];
  logic [127:0] key       [NI];
  logic [127:0] iv        [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         busy      [NI];
  logic [127:0] cipher    [NI];

  ece571f23_g5_aes_cipher_iter #(.UNROLL(1), .CBC_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .plaintext(plaintext[0]), .key(key[0]), .iv_load(iv_load[0]), .iv(iv[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .cipher(cipher[0]), .busy(busy[0]));

  ece571f23_g5_aes_cipher_iter #(.UNROLL(2), .CBC_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .plaintext(plaintext[1]), .key(key[1]), .iv_load(iv_load[1]), .iv(iv[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .cipher(cipher[1]), .busy(busy[1]));

  ece571f23_g5_aes_cipher_iter #(.UNROLL(5), .CBC_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .plaintext(plaintext[2]), .key(key[2]), .iv_load(iv_load[2]), .iv(iv[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .cipher(cipher[2]), .busy(busy[2]));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sb [256];
  logic [127:0] m_chain [NI];
  logic [127:0] m_exp   [NI];

  localparam logic [127:0] K_STD  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P_B2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C_ECB1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] IV_STD = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CBC1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C_CBC2 = 128'h5086cb9b507219ee95db113a917678b2;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Textbook AES-128 on a byte array, with the full expanded key schedule up front
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  x;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(((i/4) + (i%4)) % 4) * 4 + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd != 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block; hs_now also completes the pending output handshake on the same edge
  task automatic accept_block(input int i, input logic [127:0] pt, input logic [127:0] k,
                              input logic ld, input logic [127:0] ivv, input logic hs_now);
    int cnt = 0;
    if (hs_now) out_ready[i] = 1'b1;
    #1;
    while (!in_ready[i] && cnt < 40) begin
      tick();
      cnt++;
    end
    check($sformatf("ready_wait%0d", i), 128'(cnt < 40), 128'(1));
    if (i == 2 && hs_now) m_chain[i] = m_exp[i];
    if (i == 2 && ld && !hs_now) m_chain[i] = ivv;
    m_exp[i] = aes_ref(pt ^ ((i == 2) ? m_chain[i] : 128'h0), k);
    in_valid[i] = 1'b1; plaintext[i] = pt; key[i] = k; iv_load[i] = ld; iv[i] = ivv;
    tick();
    in_valid[i] = 1'b0; iv_load[i] = 1'b0; out_ready[i] = 1'b0;
    plaintext[i] = rnd128(); key[i] = rnd128(); iv[i] = rnd128();
    check($sformatf("busy_run%0d", i), 128'(busy[i]), 128'(1));
    check($sformatf("valid_run%0d", i), 128'(out_valid[i]), 128'(0));
    check($sformatf("ready_run%0d", i), 128'(in_ready[i]), 128'(0));
  endtask

  task automatic wait_result(input int i, input bit noise);
    int cnt = 0;
    while (!out_valid[i] && cnt < 30) begin
      if (noise) begin
        in_valid[i] = 1'($urandom); iv_load[i] = 1'($urandom);
        plaintext[i] = rnd128(); iv[i] = rnd128();
      end
      tick();
      cnt++;
    end
    in_valid[i] = 1'b0; iv_load[i] = 1'b0;
    check($sformatf("latency%0d", i), 128'(cnt), 128'(LAT[i]));
    check($sformatf("cipher%0d", i), cipher[i], m_exp[i]);
    check($sformatf("busy_done%0d", i), 128'(busy[i]), 128'(0));
  endtask

  task automatic take(input int i);
    out_ready[i] = 1'b1;
    #1;
    check($sformatf("ready_hs%0d", i), 128'(in_ready[i]), 128'(1));
    tick();
    out_ready[i] = 1'b0;
    if (i == 2) m_chain[i] = m_exp[i];
    check($sformatf("valid_drop%0d", i), 128'(out_valid[i]), 128'(0));
    check($sformatf("idle_ready%0d", i), 128'(in_ready[i]), 128'(1));
  endtask

  initial begin
    logic [7:0]   inv;
    logic [127:0] held;
    for (int xv = 0; xv < 256; xv++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(xv), 8'(y)) == 8'h01) inv = 8'(y);
      sb[xv] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; iv_load[i] = 1'b0;
      plaintext[i] = '0; key[i] = '0; iv[i] = '0;
      m_chain[i] = '0; m_exp[i] = '0;
    end
    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_valid%0d", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("rst_busy%0d", i), 128'(busy[i]), 128'(0));
      check($sformatf("rst_ready%0d", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("rst_cipher%0d", i), cipher[i], 128'h0);
    end

    // Known-answer vectors, with in_valid/iv_load noise while rounds run
    accept_block(0, P_FIPS, K_STD, 1'b0, '0, 1'b0);
    wait_result(0, 1'b1);
    check("kat_fips", cipher[0], C_FIPS);

    // Backpressure: result must hold and no new block may slip in
    held = cipher[0];
    for (int n = 0; n < 7; n++) begin
      in_valid[0] = 1'($urandom); plaintext[0] = rnd128();
      tick();
      check("bp_cipher", cipher[0], held);
      check("bp_valid", 128'(out_valid[0]), 128'(1));
      check("bp_ready", 128'(in_ready[0]), 128'(0));
    end
    in_valid[0] = 1'b0;
    take(0);

    accept_block(1, P_B1, K_STD, 1'b0, '0, 1'b0);
    wait_result(1, 1'b1);
    check("kat_u2", cipher[1], C_ECB1);
    take(1);

    accept_block(2, P_B1, K_STD, 1'b0, '0, 1'b0);
    wait_result(2, 1'b1);
    check("kat_u5", cipher[2], C_ECB1);
    take(2);

    // CBC pair, iv loaded on the accept edge, second block issued back-to-back
    accept_block(2, P_B1, K_STD, 1'b1, IV_STD, 1'b0);
    wait_result(2, 1'b1);
    check("kat_cbc1", cipher[2], C_CBC1);
    accept_block(2, P_B2, K_STD, 1'b0, '0, 1'b1);
    wait_result(2, 1'b1);
    check("kat_cbc2", cipher[2], C_CBC2);
    take(2);

    // Random blocks on every instance, mixing idle gaps and back-to-back issue
    for (int i = 0; i < NI; i++) begin
      bit b2b = 1'b0;
      for (int n = 0; n < 6; n++) begin
        accept_block(i, rnd128(), rnd128(), 1'($urandom_range(0, 2) == 0), rnd128(), b2b);
        wait_result(i, 1'b1);
        b2b = 1'($urandom);
        if (!b2b || n == 5) take(i);
      end
    end

    // Reset in the middle of a block
    accept_block(0, P_FIPS, K_STD, 1'b0, '0, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_busy", 128'(busy[0]), 128'(0));
    check("mid_rst_cipher", cipher[0], 128'h0);
    check("mid_rst_cipher2", cipher[2], 128'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < NI; i++) m_chain[i] = '0;
    #1;
    check("post_rst_ready", 128'(in_ready[0]), 128'(1));
    repeat (12) tick();
    check("aborted_no_output", 128'(out_valid[0]), 128'(0));

    accept_block(0, P_FIPS, K_STD, 1'b0, '0, 1'b0);
    wait_result(0, 1'b0);
    check("kat_after_rst", cipher[0], C_FIPS);
    take(0);
    accept_block(2, P_B1, K_STD, 1'b0, '0, 1'b0);
    wait_result(2, 1'b0);
    check("chain_cleared", cipher[2], C_ECB1);
    take(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ece571f23_g5_aes_cipher_iter.md
ECE571F23_G5_AES_CIPHER_ITER -- requirements
Module: ece571f23_g5_aes_cipher_iter

Interface
REQ-001 Parameter UNROLL, default 1; AES rounds computed per clock; legal values 1, 2, 5.
REQ-002 Parameter CBC_EN, default 0; 0 = ECB, 1 = CBC chaining.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  plaintext/key offered.
REQ-006 in_ready  output  1  core can accept a block.
REQ-007 plaintext  input  128  block to encrypt; byte 0 at [127:120].
REQ-008 key  input  128  AES-128 cipher key; same byte order.
REQ-009 iv_load  input  1  single-cycle strobe; loads iv into the chain register.
REQ-010 iv  input  128  CBC initial vector; ignored when CBC_EN=0.
REQ-011 out_valid  output  1  cipher holds a valid result.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 cipher  output  128  ciphertext.
REQ-014 busy  output  1  high while rounds are in progress.

Function
REQ-015 FSM states are IDLE, RUN and DONE.
REQ-016 in_ready is high in IDLE, and in DONE when out_ready=1; it is low in RUN.
REQ-017 Accept occurs on an edge with in_valid&&in_ready; at that edge the core latches state = plaintext^key, or plaintext^chain^key when CBC_EN=1, sets round=1 and the round key to key, and enters RUN.
REQ-018 RUN: each edge applies UNROLL full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) with on-the-fly key expansion; round 10 omits MixColumns.
REQ-019 Round counter is 4 bits and increments by UNROLL per edge; when it reaches 10, RUN moves to DONE.
REQ-020 Latency is 10/UNROLL edges from the accept edge to out_valid=1 (10, 5 or 2).
REQ-021 In DONE, out_valid=1 and cipher is held stable until an edge with out_ready=1.
REQ-022 An edge with out_ready=1 in DONE and no new accept returns the FSM to IDLE and drops out_valid.
REQ-023 Simultaneous output handshake and input accept in DONE starts a new block directly (DONE->RUN) with no bubble.
REQ-024 CBC: chain is updated to cipher at the output-handshake edge; a back-to-back accept in the same edge uses the new cipher as chain.
REQ-025 iv_load in IDLE loads chain <= iv.
REQ-026 iv_load in RUN or DONE is ignored.
REQ-027 iv_load coincident with an accept loads chain first, and the accepted block uses the new iv.
REQ-028 in_valid while in RUN is ignored and no data is latched.
REQ-029 plaintext and key are sampled only at the accept edge and may change afterwards.
REQ-030 busy = (state==RUN).

Reset
REQ-031 rst_n low at any time, including mid-RUN, immediately forces IDLE and clears state, round key, round counter, chain and cipher to 0; out_valid=0, busy=0, in_ready=1 after reset release.
REQ-032 An aborted block produces no output.

Structure
REQ-033 Shared package ece571f23_g5_aes_pkg holds the S-box function, the Rcon table, the 128-bit state typedef, the FSM state enum and the constant NR=10.
REQ-034 One sub-module, ece571f23_g5_aes_round, is combinational: state in, round key in, Rcon in, last-round flag in; next state and next round key out.
REQ-035 ece571f23_g5_aes_round is instantiated UNROLL times in a generate chain.
REQ-036 An elaboration-time check rejects illegal UNROLL values.

Verification
REQ-037 ECB, UNROLL=1: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> cipher 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
REQ-038 ECB, UNROLL=2 and UNROLL=5: plaintext 6bc1bee22e409f96e93d7e117393172a, key 2b7e151628aed2a6abf7158809cf4f3c -> 3ad77bb40d7a3660a89ecaf32466ef97 after 5 and 2 edges respectively.
REQ-039 CBC, iv 000102030405060708090a0b0c0d0e0f, key 2b7e1516..., blocks 6bc1bee2...172a then ae2d8a571e03ac9c9eb76fac45af8e51 issued back-to-back (out_ready=1) -> 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2, no idle cycle between them.
REQ-040 Backpressure: out_ready=0 for 7 cycles in DONE -> cipher and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> single handshake.
REQ-041 Reset mid-operation: rst_n low at round 4 -> outputs cleared asynchronously; the next block encrypts correctly (REQ-037 vector) and chain is reset to 0.
